uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-002 Parameter OVERSAMPLE, default 16, RX_TICK pulses per bit period; fixed at 16 in this release.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 RX_TICK  input  1  one-clk-wide 16x oversampling strobe from Baud_Generator.
REQ-006 RX_IN  input  1  asynchronous serial line, idle high.
REQ-007 RX_DATA  output  DATA_BITS  last correctly framed byte, LSB = first received data bit.
REQ-008 RX_DONE  output  1  one-clk pulse: RX_DATA updated with a new good frame.
REQ-009 RX_FRAME_ERR  output  1  one-clk pulse: stop bit sampled low.

Function
REQ-010 RX_IN shall pass through a 2-flop synchronizer (reset value 1) before any use; the synchronized line is "rxs".
REQ-011 All counters and the FSM shall advance only in clk cycles where RX_TICK=1; in other cycles all state holds.
REQ-012 FSM states: IDLE, START, DATA, STOP; 4-bit tick counter; bit counter sized for DATA_BITS-1.
REQ-013 IDLE: an armed flag sets when rxs=1 on a tick; with armed set, rxs=0 on a tick -> START, tick counter cleared.
REQ-014 START: on the tick where tick counter reaches 7 (mid start bit), rxs=0 -> DATA, tick counter cleared; rxs=1 -> IDLE, no output pulse (glitch reject).
REQ-015 DATA: on each tick where tick counter reaches 15, rxs shall be shifted into the shift register LSB-first and the tick counter wraps to 0; after bit DATA_BITS-1 -> STOP.
REQ-016 STOP: on the tick where tick counter reaches 15, rxs=1 -> RX_DATA loaded from shift register, RX_DONE pulsed; rxs=0 -> RX_FRAME_ERR pulsed, RX_DATA unchanged, armed flag cleared.
REQ-017 After STOP the FSM shall return to IDLE in the same tick cycle; a new start bit is accepted from the next tick onward (back-to-back frames supported).
REQ-018 RX_DONE and RX_FRAME_ERR shall be registered, asserted for exactly one clk in the cycle following the stop-sample tick, and never asserted together.
REQ-019 Latency, synchronized falling edge to RX_DONE: 8 + 16*DATA_BITS + 16 ticks, plus 1 clk.
REQ-020 RX_DATA shall hold its value between RX_DONE pulses, including across framing errors.
REQ-021 RX_TICK asserted every cycle shall be legal (functional, at clk/16 bit rate).

Reset
REQ-022 On reset: FSM=IDLE, armed=0, counters=0, shift register=0, RX_DATA=0, RX_DONE=0, RX_FRAME_ERR=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame shall abandon the frame with no output pulse; after release the block shall require rxs=1 before accepting a start bit.

Structure
REQ-024 FSM state encoding and the OVERSAMPLE constant, with mid-bit (7) and end-bit (15) tick counts, belong in the shared uart package for reuse by the transmitter.
REQ-025 The 2-flop synchronizer shall be a separate sub-module named sync_2ff (reset value parameterized).
REQ-026 Target size 120-250 RTL lines; no FIFO inside this block.

Verification (Baud_Generator at CLK_FREQ=50_000_000, BAUD_RATE=9600: RX_TICK every 325 clk; bench drives 5200-clk bits)
REQ-027 Frame 0xA5, good stop -> RX_DATA=0xA5, RX_DONE high exactly 1 clk, RX_FRAME_ERR=0.
REQ-028 Back-to-back frames 0x00 then 0xFF, no idle gap -> two RX_DONE pulses, RX_DATA=0x00 then 0xFF.
REQ-029 RX_IN low for 4 ticks (1300 clk), then high -> no RX_DONE, no RX_FRAME_ERR, FSM back in IDLE.
REQ-030 Frame 0x3C with stop bit low, after prior good 0x5A -> RX_FRAME_ERR 1 clk, RX_DATA stays 0x5A; next start accepted only after line returns high.
REQ-031 reset pulsed during data bit 4 of 0x81 -> all outputs 0 immediately, no pulse; subsequent frame 0x81 received correctly.
REQ-032 DATA_BITS=5, frame 0x15 -> RX_DATA=5'h15, RX_DONE 1 clk after 8+80+16 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding and 16x oversampling tick positions,
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned TICK_MID   = OVERSAMPLE / 2 - 1;
  localparam int unsigned TICK_END   = OVERSAMPLE - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selectable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB first, one stop bit.
// Outputs a one-clk RX_DONE per good frame or RX_FRAME_ERR on a low stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RX_TICK,
  input  logic                 RX_IN,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_DONE,
  output logic                 RX_FRAME_ERR
);

  localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] MID_CNT  = TICK_W'(TICK_MID);
  localparam logic [TICK_W-1:0] END_CNT  = TICK_W'(TICK_END);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS must be in 5..8");
  end
  if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_oversample
    $error("uart_rx: only 16x oversampling is supported");
  end

  logic                 rxs;
  uart_state_e          state;
  logic                 armed;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (RX_IN),
    .q    (rxs)
  );

  // Receive FSM; everything except the output pulses holds between ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      RX_DATA      <= '0;
      RX_DONE      <= 1'b0;
      RX_FRAME_ERR <= 1'b0;
    end else begin
      RX_DONE      <= 1'b0;
      RX_FRAME_ERR <= 1'b0;
      if (RX_TICK) begin
        case (state)
          ST_IDLE: begin
            // A start edge only counts once the line has been seen idle high.
            if (rxs) begin
              armed <= 1'b1;
            end else if (armed) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == MID_CNT) begin
              tick_cnt <= '0;
              if (rxs) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (tick_cnt == END_CNT) begin
              tick_cnt  <= '0;
              shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                state <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (tick_cnt == END_CNT) begin
              tick_cnt <= '0;
              state    <= ST_IDLE;
              if (rxs) begin
                RX_DATA <= shift_reg;
                RX_DONE <= 1'b1;
              end else begin
                RX_FRAME_ERR <= 1'b1;
                armed        <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: 8-bit instance with a tick every 4 clk,
// plus a 5-bit instance with a tick every clk for the latency check.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_tick;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;

  logic       rx_in5;
  logic [4:0] rx_data5;
  logic       rx_done5;
  logic       rx_err5;

  logic [1:0] tick_div = 2'd0;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) tick_div <= tick_div + 2'd1;
  assign rx_tick = (tick_div == 2'd3);

  uart_rx #(.DATA_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .RX_TICK     (rx_tick),
    .RX_IN       (rx_in),
    .RX_DATA     (rx_data),
    .RX_DONE     (rx_done),
    .RX_FRAME_ERR(rx_err)
  );

  uart_rx #(.DATA_BITS(5)) dut5 (
    .clk         (clk),
    .reset       (reset),
    .RX_TICK     (1'b1),
    .RX_IN       (rx_in5),
    .RX_DATA     (rx_data5),
    .RX_DONE     (rx_done5),
    .RX_FRAME_ERR(rx_err5)
  );

  // Pulse counters: a pulse held for two clk counts twice.
  always @(negedge clk) begin
    if (rx_done) done_cnt++;
    if (rx_err) err_cnt++;
    if ((rx_done && rx_err) || (rx_done5 && rx_err5)) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLK);
    send_bit(stop, BIT_CLK);
  endtask

  function automatic logic frame5_bit(input int j, input logic [4:0] d);
    int idx;
    idx = j / 16;
    if (idx == 0) return 1'b0;
    if (idx <= 5) return d[idx-1];
    return 1'b1;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap_bits;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0, e0, first_j, hi5, err5;
    logic [4:0] f5;

    vecs[0] = '{8'hA5, 1'b1, 1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
    vecs[3] = '{8'h5A, 1'b1, 1, 1, 0, 8'h5A};
    vecs[4] = '{8'h3C, 1'b0, 2, 0, 1, 8'h5A};
    vecs[5] = '{8'hC3, 1'b1, 1, 1, 0, 8'hC3};

    reset  = 1'b1;
    rx_in  = 1'b1;
    rx_in5 = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_done", 32'(rx_done), 32'h0);
    check("reset_rx_err", 32'(rx_err), 32'h0);
    check("reset_rx_data5", 32'(rx_data5), 32'h0);
    reset = 1'b0;
    send_bit(1'b1, 2 * BIT_CLK);

    // Table: good frames, back-to-back frames, framing error holding data.
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      send_bit(1'b1, vecs[i].gap_bits * BIT_CLK);
      check($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
    end

    // Framing error with the line left low: no restart until it goes high.
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    send_bit(1'b0, 2 * BIT_CLK);
    check("err_low_hold_data", 32'(rx_data), 32'hC3);
    send_bit(1'b1, 2 * BIT_CLK);
    send_frame(8'h96, 1'b1);
    send_bit(1'b1, BIT_CLK);
    check("err_low_done", 32'(done_cnt - d0), 32'd1);
    check("err_low_err", 32'(err_cnt - e0), 32'd1);
    check("err_low_rx_data", 32'(rx_data), 32'h96);

    // Four-tick glitch on the start bit is rejected silently.
    d0 = done_cnt;
    e0 = err_cnt;
    send_bit(1'b0, 16);
    send_bit(1'b1, 3 * BIT_CLK);
    check("glitch_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h69, 1'b1);
    send_bit(1'b1, BIT_CLK);
    check("post_glitch_done", 32'(done_cnt - d0), 32'd1);
    check("post_glitch_rx_data", 32'(rx_data), 32'h69);

    // Reset during data bit 4 of 0x81; released with the line still low.
    d0 = done_cnt;
    e0 = err_cnt;
    send_bit(1'b0, BIT_CLK);
    send_bit(1'b1, BIT_CLK);
    send_bit(1'b0, 3 * BIT_CLK);
    send_bit(1'b0, BIT_CLK / 2);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_rx_data", 32'(rx_data), 32'h0);
    check("midrst_rx_done", 32'(rx_done), 32'h0);
    check("midrst_rx_err", 32'(rx_err), 32'h0);
    for (int k = 0; k < 8 && tick_div != 2'd0; k++) @(negedge clk);
    reset = 1'b0;
    send_bit(1'b0, 24);
    send_bit(1'b0, 2 * BIT_CLK);
    send_bit(1'b1, BIT_CLK);
    send_bit(1'b1, BIT_CLK);
    send_bit(1'b1, 2 * BIT_CLK);
    check("abandon_done", 32'(done_cnt - d0), 32'd0);
    check("abandon_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h81, 1'b1);
    send_bit(1'b1, BIT_CLK);
    check("after_rst_done", 32'(done_cnt - d0), 32'd1);
    check("after_rst_rx_data", 32'(rx_data), 32'h81);

    // 5-bit frame 0x15 with a tick every clk: RX_DONE at 2 sync + 104 ticks.
    f5 = 5'h15;
    first_j = -1;
    hi5 = 0;
    err5 = 0;
    for (int j = 0; j < 160; j++) begin
      @(negedge clk);
      rx_in5 = frame5_bit(j, f5);
      @(posedge clk);
      #1;
      if (rx_done5) begin
        hi5++;
        if (first_j < 0) first_j = j;
      end
      if (rx_err5) err5++;
    end
    check("db5_latency", 32'(first_j), 32'd106);
    check("db5_done_width", 32'(hi5), 32'd1);
    check("db5_rx_data", 32'(rx_data5), 32'h15);
    check("db5_err", 32'(err5), 32'd0);

    check("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
